// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, req/ack halfword fetch, prefetch FIFO and registered output to decode.
// Define FETCH_BYPASS_EN to let a response load the output register directly when the FIFO is empty.
module fetch_stage #(
    parameter int              AW         = 32,
    parameter logic [AW-1:0]   RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 2,
    parameter logic [15:0]     NOP_INSN   = 16'hBF00
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_stall,
    input  logic          i_flush,
    input  logic [AW-1:0] i_branch_target,
    input  logic          i_mem_busy,
    output logic          o_imem_req,
    output logic [AW-1:0] o_imem_addr,
    input  logic          i_imem_ack,
    input  logic [15:0]   i_imem_rdata,
    output logic [15:0]   o_ir,
    output logic [AW-1:0] o_pc,
    output logic          o_valid
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [AW-1:0] pc, pc_next, target, addr;
    logic          req, discard;
    logic [15:0]   fifo_ir [FIFO_DEPTH];
    logic [AW-1:0] fifo_pc [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_next;
    logic          xfer, accept, bypass, push, pop, issue;

    assign target      = i_branch_target & ~AW'(1);
    assign xfer        = req && i_imem_ack;
    assign accept      = xfer && !discard && !i_flush;
`ifdef FETCH_BYPASS_EN
    assign bypass      = accept && !i_stall && (count == '0);
`else
    assign bypass      = 1'b0;
`endif
    assign push        = accept && !bypass;
    assign pop         = !i_flush && !i_stall && (count != '0);
    assign o_imem_req  = req;
    assign o_imem_addr = addr;

    // A new request is only considered once the current one has completed, so
    // reserving space against the post-edge count keeps the FIFO from overflowing.
    always_comb begin
        count_next = count;
        pc_next    = pc;
        if (i_flush) begin
            count_next = '0;
            pc_next    = target;
        end else begin
            count_next = count + CW'(push) - CW'(pop);
            if (xfer && !discard)
                pc_next = pc + AW'(2);
        end
        issue = (!req || xfer) && !i_mem_busy && (count_next < DEPTH_C);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc      <= RESET_PC;
            req     <= 1'b0;
            addr    <= RESET_PC;
            discard <= 1'b0;
            count   <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_ir    <= NOP_INSN;
            o_pc    <= RESET_PC;
            o_valid <= 1'b0;
        end else begin
            pc    <= pc_next;
            count <= count_next;

            if (issue) begin
                req  <= 1'b1;
                addr <= pc_next;
            end else if (xfer) begin
                req <= 1'b0;
            end

            // An un-acked request at flush time cannot be withdrawn; its data is dropped on ack.
            if (i_flush)
                discard <= req && !i_imem_ack;
            else if (xfer)
                discard <= 1'b0;

            if (i_flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + PW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + PW'(1);
            end

            if (i_flush) begin
                o_ir    <= NOP_INSN;
                o_valid <= 1'b0;
            end else if (!i_stall) begin
                if (count != '0) begin
                    o_ir    <= fifo_ir[rd_ptr];
                    o_pc    <= fifo_pc[rd_ptr];
                    o_valid <= 1'b1;
                end else if (bypass) begin
                    o_ir    <= i_imem_rdata;
                    o_pc    <= addr;
                    o_valid <= 1'b1;
                end else begin
                    o_ir    <= NOP_INSN;
                    o_valid <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_ir[wr_ptr] <= i_imem_rdata;
            fifo_pc[wr_ptr] <= addr;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with a reactive instruction memory (rdata = addr[16:1]).
module tb_fetch_stage;

    localparam int AW = 32;
    localparam logic [31:0] NOP = 32'h0000_BF00;
`ifdef FETCH_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_stall = 1'b0;
    logic          i_flush = 1'b0;
    logic [AW-1:0] i_branch_target = '0;
    logic          i_mem_busy = 1'b0;
    logic          o_imem_req;
    logic [AW-1:0] o_imem_addr;
    logic          i_imem_ack = 1'b0;
    logic [15:0]   i_imem_rdata = '0;
    logic [15:0]   o_ir;
    logic [AW-1:0] o_pc;
    logic          o_valid;

    int checks = 0;
    int passes = 0;
    int memWait = 0;
    bit memHold = 1'b0;
    int waitCount = 0;

    fetch_stage dut (
        .clk(clk), .rst(rst), .i_stall(i_stall), .i_flush(i_flush),
        .i_branch_target(i_branch_target), .i_mem_busy(i_mem_busy),
        .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
        .i_imem_ack(i_imem_ack), .i_imem_rdata(i_imem_rdata),
        .o_ir(o_ir), .o_pc(o_pc), .o_valid(o_valid)
    );

    always #5 clk = ~clk;

    // Memory answers after memWait idle cycles; memHold withholds the ack entirely.
    always @(negedge clk) begin
        if (!o_imem_req || memHold) begin
            i_imem_ack = 1'b0;
            waitCount  = 0;
        end else if (waitCount >= memWait) begin
            i_imem_ack   = 1'b1;
            i_imem_rdata = o_imem_addr[16:1];
            waitCount    = 0;
        end else begin
            i_imem_ack = 1'b0;
            waitCount++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected)
            passes++;
        else
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    endtask

    task automatic applyStimulus(input logic stall, input logic flush, input logic busy, input logic [31:0] target);
        i_stall         = stall;
        i_flush         = flush;
        i_mem_busy      = busy;
        i_branch_target = target;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic resetDut();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        rst = 1'b1;
        tick(1);
        checkOutput("rst_drops_req", 32'(o_imem_req), 32'h0);
        tick(1);
        rst = 1'b0;
    endtask

    initial begin
        // Reset state, then zero-wait sequential fetch
        memWait = 0;
        memHold = 1'b0;
        resetDut();
        checkOutput("rst_req",   32'(o_imem_req), 32'h0);
        checkOutput("rst_addr",  o_imem_addr,     32'h0);
        checkOutput("rst_ir",    32'(o_ir),       NOP);
        checkOutput("rst_pc",    o_pc,            32'h0);
        checkOutput("rst_valid", 32'(o_valid),    32'h0);
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            checkOutput("seq_req",   32'(o_imem_req), 32'h1);
            checkOutput("seq_addr",  o_imem_addr,     32'(2 * (k - 1)));
            checkOutput("seq_valid", 32'(o_valid),    32'(k >= LAT + 1));
            if (k >= LAT + 1) begin
                checkOutput("seq_ir", 32'(o_ir), 32'(k - 1 - LAT));
                checkOutput("seq_pc", o_pc,      32'(2 * (k - 1 - LAT)));
            end else begin
                checkOutput("seq_ir_nop", 32'(o_ir), NOP);
            end
        end

`ifndef FETCH_BYPASS_EN
        // Stall for 5 cycles with 1-wait memory: outputs freeze, FIFO fills, req stops
        memWait = 1;
        resetDut();
        tick(6);
        checkOutput("stall_pre_ir", 32'(o_ir), 32'h1);
        checkOutput("stall_pre_pc", o_pc,      32'h2);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        for (int k = 7; k <= 11; k++) begin
            tick(1);
            checkOutput("stall_ir",    32'(o_ir),    32'h1);
            checkOutput("stall_pc",    o_pc,         32'h2);
            checkOutput("stall_valid", 32'(o_valid), 32'h1);
            if (k >= 9)
                checkOutput("stall_req_low", 32'(o_imem_req), 32'h0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        tick(1);
        checkOutput("unstall_ir0",   32'(o_ir),       32'h2);
        checkOutput("unstall_pc0",   o_pc,            32'h4);
        checkOutput("unstall_req",   32'(o_imem_req), 32'h1);
        checkOutput("unstall_addr",  o_imem_addr,     32'h8);
        tick(1);
        checkOutput("unstall_ir1",   32'(o_ir),       32'h3);
        checkOutput("unstall_pc1",   o_pc,            32'h6);
        tick(1);
        checkOutput("unstall_gap",   32'(o_valid),    32'h0);
        tick(1);
        checkOutput("resume_ir",     32'(o_ir),       32'h4);
        checkOutput("resume_pc",     o_pc,            32'h8);

        // Flush while the request at 0x20 is pending; its late ack must be discarded
        memWait = 0;
        resetDut();
        tick(16);
        memHold = 1'b1;
        tick(1);
        checkOutput("fl_pend_addr", o_imem_addr,     32'h20);
        checkOutput("fl_pend_req",  32'(o_imem_req), 32'h1);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h100);
        tick(1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("fl_hold_addr", o_imem_addr,     32'h20);
        checkOutput("fl_hold_req",  32'(o_imem_req), 32'h1);
        checkOutput("fl_ir_nop",    32'(o_ir),       NOP);
        tick(1);
        checkOutput("fl_hold_addr2", o_imem_addr,    32'h20);
        memHold = 1'b0;
        for (int k = 20; k <= 22; k++) begin
            tick(1);
            checkOutput("fl_no_valid", 32'(o_valid), 32'h0);
            if (k == 21)
                checkOutput("fl_new_addr", o_imem_addr, 32'h100);
        end
        tick(1);
        checkOutput("fl_first_valid", 32'(o_valid), 32'h1);
        checkOutput("fl_first_pc",    o_pc,          32'h100);
        checkOutput("fl_first_ir",    32'(o_ir),     32'h80);

        // Data-memory busy for 4 cycles: no requests, FIFO drains to NOP, PC holds
        resetDut();
        tick(6);
        checkOutput("busy_pre_addr", o_imem_addr, 32'hA);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0);
        for (int k = 7; k <= 10; k++) begin
            tick(1);
            checkOutput("busy_req_low", 32'(o_imem_req), 32'h0);
            if (k == 7)
                checkOutput("busy_drain_ir0", 32'(o_ir), 32'h4);
            if (k == 8)
                checkOutput("busy_drain_ir1", 32'(o_ir), 32'h5);
            if (k == 9) begin
                checkOutput("busy_empty_valid", 32'(o_valid), 32'h0);
                checkOutput("busy_empty_ir",    32'(o_ir),    NOP);
                checkOutput("busy_empty_pc",    o_pc,         32'hA);
            end
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        tick(1);
        checkOutput("busy_resume_req",  32'(o_imem_req), 32'h1);
        checkOutput("busy_resume_addr", o_imem_addr,     32'hC);

        // Flush coinciding with an ack and a stall; odd target has bit0 cleared
        resetDut();
        tick(5);
        checkOutput("fa_pre_ir", 32'(o_ir), 32'h2);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h101);
        tick(1);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkOutput("fa_valid",    32'(o_valid),    32'h0);
        checkOutput("fa_ir_nop",   32'(o_ir),       NOP);
        checkOutput("fa_new_addr", o_imem_addr,     32'h100);
        checkOutput("fa_new_req",  32'(o_imem_req), 32'h1);
        tick(1);
        checkOutput("fa_valid2",   32'(o_valid),    32'h0);
        tick(1);
        checkOutput("fa_first_valid", 32'(o_valid), 32'h1);
        checkOutput("fa_first_pc",    o_pc,         32'h100);
        checkOutput("fa_first_ir",    32'(o_ir),    32'h80);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
